// File: rtl/operand_entry.sv
// Three-step operand entry: two push-buttons (enter, clear) are synchronized,
// debounced and edge-detected. Successive enter presses capture the switch
// bank as A, then B, then ctrl, after which the operation is presented with
// op_valid until the consumer takes it with op_ready.
//
// Handshake: op_valid is high exactly while an operation is presented, and
// A/B/ctrl are held stable for that whole time. The operation is consumed on
// the first rising edge where op_valid && op_ready; op_valid drops after that
// edge. op_ready is ignored while op_valid is low.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       op_ready,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] ctrl,
  output logic       op_valid,
  output logic [1:0] stage
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_CTRL  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  // Index 0 is enter, index 1 is clear.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    settle;   // marks when sync2 holds real post-reset samples
  logic [1:0]    lvl;      // accepted (debounced) level
  logic [1:0]    lvl_d;    // accepted level one cycle ago
  logic [1:0]    armed;    // button has been seen released since reset
  logic [CW-1:0] cnt [2];
  logic [1:0]    press;
  state_t        state;

  // Two-flop synchronizers, plus a matching shift register that tells the
  // arming logic when the synchronizer output is no longer reset filler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      settle <= '0;
    end else begin
      sync1  <= {btn_clear, btn_enter};
      sync2  <= sync1;
      settle <= {settle[0], 1'b1};
    end
  end

  // Debounce: the counter restarts whenever the sample agrees with the
  // accepted level, so only DEBOUNCE_CYCLES consecutive disagreeing samples
  // move the accepted level. A button is armed only once it has been seen
  // released, so a button held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl   <= '0;
      lvl_d <= '0;
      armed <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      lvl_d <= lvl;
      armed <= armed | (settle[1] ? ~sync2 : 2'b00);
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          lvl[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // One-cycle press pulse on a rising accepted level.
  assign press = lvl & ~lvl_d & armed;

  // Entry sequencer; clear has priority over enter and over op_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_A;
      A        <= '0;
      B        <= '0;
      ctrl     <= '0;
      op_valid <= 1'b0;
    end else if (press[1]) begin
      state    <= S_A;
      A        <= '0;
      B        <= '0;
      ctrl     <= '0;
      op_valid <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (press[0]) begin
            A     <= sw;
            state <= S_B;
          end
        end
        S_B: begin
          if (press[0]) begin
            B     <= sw;
            state <= S_CTRL;
          end
        end
        S_CTRL: begin
          if (press[0]) begin
            ctrl     <= sw;
            state    <= S_VALID;
            op_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (op_ready) begin
            state    <= S_A;
            op_valid <= 1'b0;
          end
        end
        default: begin
          state    <= S_A;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with a short debounce window.
module tb_operand_entry;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       op_ready = 1'b0;
  logic [2:0] A, B, ctrl;
  logic       op_valid;
  logic [1:0] stage;

  operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .op_ready(op_ready), .A(A), .B(B), .ctrl(ctrl),
    .op_valid(op_valid), .stage(stage)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // monitor state
  logic [1:0] stage_log[$];
  logic [1:0] prev_stage = 2'd0;
  logic       prev_valid = 1'b0;
  int         valid_cycles = 0;
  bit         sb_on = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: stage change log, op_valid cycle count, operation scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stage = 2'd0;
      prev_valid = 1'b0;
    end else begin
      if (stage != prev_stage) begin
        stage_log.push_back(stage);
        prev_stage = stage;
      end
      if (op_valid) valid_cycles++;
      if (sb_on && op_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("sb_unexpected_op", {23'd0, A, B, ctrl}, 32'hffff_ffff);
        else check("sb_op", {23'd0, A, B, ctrl}, {23'd0, exp_q.pop_front()});
      end
      prev_valid = op_valid;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    op_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic press_enter(input logic [2:0] v);
    sw = v;
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(10);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic pulse_ready();
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_outs(input string name, input logic [1:0] es, input logic [2:0] ea,
                            input logic [2:0] eb, input logic [2:0] ec, input logic ev);
    check({name, "_stage"}, stage, es);
    check({name, "_A"}, A, ea);
    check({name, "_B"}, B, eb);
    check({name, "_ctrl"}, ctrl, ec);
    check({name, "_valid"}, op_valid, ev);
  endtask

  typedef struct {
    int         act;  // 0 enter, 1 clear, 2 ready pulse
    logic [2:0] sw;
    logic [1:0] es;
    logic [2:0] ea, eb, ec;
    logic       ev;
  } row_t;

  row_t tbl[9];

  // reference model for random phase
  int         m_stage;
  logic [2:0] m_reg[3];

  initial begin
    int lat;
    int bad;
    int vc_mark;
    logic [2:0] v;
    int r;

    // asynchronous reset state, before any clock edge
    #1;
    check_outs("reset", 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // table-driven sequence
    tbl[0] = '{0, 3'd3, 2'd1, 3'd3, 3'd0, 3'd0, 1'b0};
    tbl[1] = '{0, 3'd2, 2'd2, 3'd3, 3'd2, 3'd0, 1'b0};
    tbl[2] = '{0, 3'd2, 2'd3, 3'd3, 3'd2, 3'd2, 1'b1};
    tbl[3] = '{2, 3'd0, 2'd0, 3'd3, 3'd2, 3'd2, 1'b0};
    tbl[4] = '{2, 3'd0, 2'd0, 3'd3, 3'd2, 3'd2, 1'b0};
    tbl[5] = '{0, 3'd7, 2'd1, 3'd7, 3'd2, 3'd2, 1'b0};
    tbl[6] = '{2, 3'd0, 2'd1, 3'd7, 3'd2, 3'd2, 1'b0};
    tbl[7] = '{0, 3'd6, 2'd2, 3'd7, 3'd6, 3'd2, 1'b0};
    tbl[8] = '{1, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0};
    vc_mark = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) vc_mark = valid_cycles;
      case (tbl[i].act)
        0: press_enter(tbl[i].sw);
        1: press_clear();
        default: pulse_ready();
      endcase
      check_outs($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ev);
    end
    check("clear_in_ctrl_no_valid", valid_cycles - vc_mark, 0);

    // full entry with op_ready held high: valid for exactly one cycle
    do_reset();
    stage_log.delete();
    valid_cycles = 0;
    op_ready = 1'b1;
    press_enter(3'd3);
    press_enter(3'd2);
    press_enter(3'd2);
    op_ready = 1'b0;
    check_outs("ready_held", 2'd0, 3'd3, 3'd2, 3'd2, 1'b0);
    check("ready_held_valid_cycles", valid_cycles, 1);
    check("ready_held_log_size", stage_log.size(), 4);
    if (stage_log.size() == 4)
      check("ready_held_log", {stage_log[0], stage_log[1], stage_log[2], stage_log[3]}, 8'b01_10_11_00);

    // press latency from raw edge to stage change
    do_reset();
    sw = 3'd3;
    btn_enter = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (stage != 2'd0) begin
        lat = k;
        break;
      end
    end
    check("latency_in_range", (lat >= DB + 2 && lat <= DB + 4), 1);
    if (lat != DB + 3) $display("note: press latency %0d cycles", lat);
    btn_enter = 1'b0;
    tick(12);

    // bouncing enter: one press only
    do_reset();
    stage_log.delete();
    for (int k = 0; k < 5; k++) begin
      btn_enter = 1'b1;
      tick(2);
      btn_enter = 1'b0;
      tick(2);
    end
    check("bounce_no_early_press", stage, 2'd0);
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(10);
    check("bounce_stage", stage, 2'd1);
    check("bounce_one_change", stage_log.size(), 1);

    // presented operation held while op_ready is low
    do_reset();
    press_enter(3'd5);
    press_enter(3'd1);
    press_enter(3'd4);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (op_valid !== 1'b1 || stage !== 2'd3 || {A, B, ctrl} !== {3'd5, 3'd1, 3'd4}) bad++;
    end
    check("hold_stable_cycles_bad", bad, 0);
    press_enter(3'd2);
    check_outs("hold_extra_enter", 2'd3, 3'd5, 3'd1, 3'd4, 1'b1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check_outs("hold_release", 2'd0, 3'd5, 3'd1, 3'd4, 1'b0);

    // enter and clear together in S_B
    do_reset();
    press_enter(3'd4);
    sw = 3'd6;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(10);
    check_outs("enter_and_clear", 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // asynchronous reset in S_VALID with enter held through release
    do_reset();
    press_enter(3'd1);
    press_enter(3'd2);
    press_enter(3'd3);
    check("pre_reset_valid", op_valid, 1'b1);
    btn_enter = 1'b1;
    tick(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_reset", 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sw = 3'd5;
    tick(20);
    check("held_through_reset_no_press", stage, 2'd0);
    btn_enter = 1'b0;
    tick(10);
    press_enter(3'd5);
    check("after_rerelease_stage", stage, 2'd1);
    check("after_rerelease_A", A, 3'd5);

    // randomized transactions against the reference model
    do_reset();
    m_stage = 0;
    for (int j = 0; j < 3; j++) m_reg[j] = 3'd0;
    exp_q.delete();
    sb_on = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        v = 3'($urandom_range(0, 7));
        if (m_stage < 3) begin
          if (m_stage == 2) exp_q.push_back({m_reg[0], m_reg[1], v});
          m_reg[m_stage] = v;
          m_stage++;
          if (m_stage == 3 && op_ready) m_stage = 0;
        end
        press_enter(v);
      end else if (r < 8) begin
        op_ready = 1'($urandom_range(0, 1));
        tick(2);
        if (op_ready && m_stage == 3) m_stage = 0;
      end else begin
        for (int j = 0; j < 3; j++) m_reg[j] = 3'd0;
        m_stage = 0;
        press_clear();
      end
      check_outs($sformatf("rand%0d", it), 2'(m_stage), m_reg[0], m_reg[1], m_reg[2], m_stage == 3);
    end
    tick(2);
    sb_on = 1'b0;
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable synchronized samples required before a button level is accepted (>=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sw  input  3  raw switch bank; value captured as A, B or ctrl.
REQ-005 btn_enter  input  1  raw asynchronous push-button; press commits the current sw value.
REQ-006 btn_clear  input  1  raw asynchronous push-button; press aborts entry.
REQ-007 op_ready  input  1  consumer accepts the presented operation when high.
REQ-008 A  output  3  captured first operand.
REQ-009 B  output  3  captured second operand.
REQ-010 ctrl  output  3  captured operation select (0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 passed through unchanged).
REQ-011 op_valid  output  1  operation complete and presented.
REQ-012 stage  output  2  current entry stage, for LED display.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized button SHALL feed its own debouncer: counter reloads on any change of the sample versus the accepted level; the accepted level updates when DEBOUNCE_CYCLES equal samples are seen.
REQ-015 A 0->1 transition of a debounced level SHALL generate a 1-cycle press pulse; release, holding or bounces shorter than DEBOUNCE_CYCLES SHALL generate no pulse.
REQ-016 Total latency from a stable raw edge to the press pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles (±1).
REQ-017 FSM states: S_A (stage=0), S_B (stage=1), S_CTRL (stage=2), S_VALID (stage=3).
REQ-018 S_A + enter pulse: A <= sw, go to S_B.
REQ-019 S_B + enter pulse: B <= sw, go to S_CTRL.
REQ-020 S_CTRL + enter pulse: ctrl <= sw, go to S_VALID.
REQ-021 The value captured SHALL be sw as sampled on the same clock edge as the press pulse (sw is quasi-static; no synchronizer required).
REQ-022 op_valid SHALL be 1 exactly while in S_VALID, registered, with A/B/ctrl stable throughout.
REQ-023 S_VALID with op_ready=1: go to S_A on the next edge; A, B, ctrl hold their values until overwritten.
REQ-024 S_VALID with op_ready=0: remain; enter pulses ignored.
REQ-025 Clear pulse in any state: go to S_A, A=B=ctrl=0, op_valid=0 next cycle.
REQ-026 Clear and enter pulses in the same cycle: clear wins; sw not captured.
REQ-027 Clear and op_ready in the same cycle in S_VALID: result identical to clear alone.
REQ-028 op_ready outside S_VALID SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock: state=S_A, stage=0, A=B=ctrl=0, op_valid=0, synchronizer flops=0, accepted button levels=0, debounce counters=0.
REQ-030 Reset asserted mid-entry or mid-debounce SHALL discard the partial entry; a button held through reset release SHALL produce no press pulse until released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 sw=3 enter, sw=2 enter, sw=2 enter, op_ready=1 -> A=3, B=2, ctrl=2, op_valid high one cycle, stage 0,1,2,3,0.
REQ-032 enter bouncing 0/1 every 2 cycles for 20 cycles, then stable high 10 cycles -> exactly one press pulse, stage 0->1 once.
REQ-033 complete entry A=5, B=1, ctrl=4 with op_ready=0 for 50 cycles -> op_valid stays 1, outputs stable; extra enter presses ignored; op_ready=1 -> stage=0 next cycle.
REQ-034 A=7, B=6 captured, clear pressed in S_CTRL -> stage=0, A=B=ctrl=0, op_valid never asserted.
REQ-035 enter and clear debounced in the same cycle in S_B -> stage=0, B not captured, outputs 0.
REQ-036 rst_n pulled low in S_VALID between clock edges -> op_valid=0 and stage=0 before the next edge; enter held through release yields no pulse.
